// File: rtl/alu_seq.sv
// Micro-sequencer for the nibble-serial ALU: LDA -> LO -> HI -> DONE, LR35902 flags.
// Define ALU_SEQ_B2B_EN to accept the next request in the same cycle a response is taken.
module alu_seq (
    input  logic       clk,
    input  logic       nreset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_fn,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_cin,
    output logic [7:0] alu_op,
    output logic       alu_la,
    output logic       alu_lb,
    output logic [2:0] alu_fn,
    output logic       alu_ci,
    output logic       alu_l,
    output logic       alu_h,
    output logic       alu_oe,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_wr,
    output logic [3:0] rsp_flags
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLda  = 3'd1;
    localparam logic [2:0] StLo   = 3'd2;
    localparam logic [2:0] StHi   = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam logic [2:0] FnAdc = 3'd1;
    localparam logic [2:0] FnSub = 3'd2;
    localparam logic [2:0] FnSbc = 3'd3;
    localparam logic [2:0] FnAnd = 3'd4;
    localparam logic [2:0] FnCp  = 3'd7;

    logic [2:0] state_q, state_d;
    logic [2:0] fn_q, fn_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       ci_q, ci_d;
    logic       hraw_q, hraw_d;
    logic       craw_q, craw_d;
    logic       zero_q, zero_d;
    logic [7:0] res_q, res_d;
    logic       accept;
    logic       arith;
    logic       done;

    always_comb begin
        req_ready = 1'b0;
        if (state_q == StIdle) begin
            req_ready = 1'b1;
        end else if (state_q == StDone) begin
`ifdef ALU_SEQ_B2B_EN
            req_ready = rsp_ready;
`else
            req_ready = 1'b0;
`endif
        end
    end

    assign accept = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        fn_d    = fn_q;
        a_d     = a_q;
        b_d     = b_q;
        ci_d    = ci_q;
        hraw_d  = hraw_q;
        craw_d  = craw_q;
        zero_d  = zero_q;
        res_d   = res_q;
        case (state_q)
            StIdle: if (accept) state_d = StLda;
            StLda:  state_d = StLo;
            StLo: begin
                hraw_d  = alu_carry;
                state_d = StHi;
            end
            StHi: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                craw_d  = alu_carry;
                state_d = StDone;
            end
            StDone: if (rsp_ready) state_d = accept ? StLda : StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            fn_d = req_fn;
            a_d  = req_a;
            b_d  = req_b;
            // Only the carry-chained ops see the incoming C flag.
            ci_d = req_cin & ((req_fn == FnAdc) | (req_fn == FnSbc));
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            fn_q    <= 3'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            ci_q    <= 1'b0;
            hraw_q  <= 1'b0;
            craw_q  <= 1'b0;
            zero_q  <= 1'b0;
            res_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            fn_q    <= fn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ci_q    <= ci_d;
            hraw_q  <= hraw_d;
            craw_q  <= craw_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        alu_op = 8'd0;
        alu_la = 1'b0;
        alu_lb = 1'b0;
        alu_fn = 3'd0;
        alu_ci = 1'b0;
        alu_l  = 1'b0;
        alu_h  = 1'b0;
        alu_oe = 1'b0;
        case (state_q)
            StLda: begin
                alu_op = a_q;
                alu_la = 1'b1;
            end
            StLo: begin
                alu_op = b_q;
                alu_lb = 1'b1;
                alu_l  = 1'b1;
                alu_fn = (fn_q == FnCp) ? FnSub : fn_q;
                alu_ci = ci_q;
            end
            StHi: begin
                alu_h  = 1'b1;
                alu_oe = 1'b1;
                alu_fn = (fn_q == FnCp) ? FnSub : fn_q;
                alu_ci = ci_q;
            end
            default: ;
        endcase
    end

    // CP is a SUB whose result is discarded but whose flags are kept.
    assign arith = ~fn_q[2] | (fn_q == FnCp);
    assign done  = (state_q == StDone);

    always_comb begin
        rsp_valid = done;
        rsp_data  = 8'd0;
        rsp_wr    = 1'b0;
        rsp_flags = 4'd0;
        if (done) begin
            rsp_data  = res_q;
            rsp_wr    = (fn_q != FnCp);
            rsp_flags = {zero_q,
                         (fn_q == FnSub) | (fn_q == FnSbc) | (fn_q == FnCp),
                         arith ? hraw_q : (fn_q == FnAnd),
                         arith & craw_q};
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural nibble-serial ALU model.
// Honours ALU_SEQ_B2B_EN for the expected back-to-back spacing.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_fn = 3'd0;
    logic [7:0] req_a = 8'd0;
    logic [7:0] req_b = 8'd0;
    logic       req_cin = 1'b0;
    logic [7:0] alu_op;
    logic       alu_la, alu_lb, alu_ci, alu_l, alu_h, alu_oe;
    logic [2:0] alu_fn;
    logic [7:0] alu_result;
    logic       alu_zero, alu_carry;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_wr;
    logic [3:0] rsp_flags;

    int total = 0;
    int bad = 0;

    alu_seq dut (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fn     (req_fn),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .alu_op     (alu_op),
        .alu_la     (alu_la),
        .alu_lb     (alu_lb),
        .alu_fn     (alu_fn),
        .alu_ci     (alu_ci),
        .alu_l      (alu_l),
        .alu_h      (alu_h),
        .alu_oe     (alu_oe),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_wr     (rsp_wr),
        .rsp_flags  (rsp_flags)
    );

    always #5 clk = ~clk;

    // Nibble-serial ALU: low nibble in L phase (B taken from the bus), high nibble in H phase.
    logic [7:0] m_a = 8'd0, m_b = 8'd0;
    logic       m_c = 1'b0;
    logic [3:0] m_lo = 4'd0;
    logic [4:0] nib;
    logic [3:0] nx, ny;
    logic       nc;

    always_comb begin
        nib = 5'd0;
        alu_result = 8'd0;
        alu_zero = 1'b0;
        alu_carry = 1'b0;
        if (alu_l) begin
            nx = m_a[3:0];
            ny = alu_op[3:0];
            nc = alu_ci;
        end else begin
            nx = m_a[7:4];
            ny = m_b[7:4];
            nc = m_c;
        end
        case (alu_fn)
            3'd0, 3'd1: nib = {1'b0, nx} + {1'b0, ny} + {4'd0, nc};
            3'd4: nib = {1'b0, nx & ny};
            3'd5: nib = {1'b0, nx ^ ny};
            3'd6: nib = {1'b0, nx | ny};
            default: nib = {1'b0, nx} - {1'b0, ny} - {4'd0, nc};
        endcase
        if (alu_fn < 3'd4 || alu_fn == 3'd7) alu_carry = nib[4];
        if (alu_h) begin
            alu_result = {nib[3:0], m_lo};
            alu_zero = ({nib[3:0], m_lo} == 8'd0);
        end
    end

    always @(posedge clk) begin
        if (alu_la) m_a <= alu_op;
        if (alu_lb) m_b <= alu_op;
        if (alu_l) begin
            m_c <= alu_carry;
            m_lo <= nib[3:0];
        end
    end

    // Per-cycle snapshot after accept: index 1 = LDA, 2 = LO, 3 = HI, 4 = DONE.
    logic [4:0] ph_strb [0:4];
    logic [7:0] ph_op [0:4];
    logic [2:0] ph_fn [0:4];
    logic       ph_ci [0:4];

    task automatic do_op(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, output int lat, output logic [7:0] data,
                         output logic [3:0] flags, output logic wr);
        int guard;
        @(negedge clk);
        req_fn = fn;
        req_a = a;
        req_b = b;
        req_cin = cin;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                ph_strb[k] = {alu_la, alu_lb, alu_l, alu_h, alu_oe};
                ph_op[k] = alu_op;
                ph_fn[k] = alu_fn;
                ph_ci[k] = alu_ci;
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) lat = 99;
        data = rsp_data;
        flags = rsp_flags;
        wr = rsp_wr;
        if (rsp_valid) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        #3;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_op !== 8'd0 ||
            {alu_la, alu_lb, alu_l, alu_h, alu_oe, alu_ci} !== 6'd0 || alu_fn !== 3'd0 ||
            rsp_data !== 8'd0 || rsp_wr !== 1'b0 || rsp_flags !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b op=%h strb=%b fn=%0d d=%h wr=%b f=%b, need rdy=1 rest 0",
                     req_ready, rsp_valid, alu_op, {alu_la, alu_lb, alu_l, alu_h, alu_oe, alu_ci},
                     alu_fn, rsp_data, rsp_wr, rsp_flags);
        end
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_arith;
        int lat;
        logic [7:0] d;
        logic [3:0] f;
        logic w;
        do_op(3'd0, 8'h3A, 8'hC6, 1'b0, lat, d, f, w);
        total++;
        if (lat !== 4 || d !== 8'h00 || f !== 4'b1011 || w !== 1'b1) begin
            bad++;
            $display("FAIL add_3a_c6: got lat=%0d d=%h f=%b wr=%b, need lat=4 d=00 f=1011 wr=1",
                     lat, d, f, w);
        end
        do_op(3'd0, 8'h01, 8'h02, 1'b1, lat, d, f, w);
        total++;
        if (d !== 8'h03 || f !== 4'b0000 || ph_ci[2] !== 1'b0) begin
            bad++;
            $display("FAIL add_ignores_cin: got d=%h f=%b ci=%b, need d=03 f=0000 ci=0",
                     d, f, ph_ci[2]);
        end
        do_op(3'd1, 8'h0F, 8'h00, 1'b1, lat, d, f, w);
        total++;
        if (d !== 8'h10 || f !== 4'b0010 || ph_ci[2] !== 1'b1) begin
            bad++;
            $display("FAIL adc_0f_00_c1: got d=%h f=%b ci=%b, need d=10 f=0010 ci=1",
                     d, f, ph_ci[2]);
        end
        do_op(3'd3, 8'h3E, 8'h3F, 1'b1, lat, d, f, w);
        total++;
        if (d !== 8'hFE || f !== 4'b0111 || w !== 1'b1) begin
            bad++;
            $display("FAIL sbc_3e_3f_c1: got d=%h f=%b wr=%b, need d=fe f=0111 wr=1", d, f, w);
        end
        total++;
        if (ph_ci[2] !== 1'b1 || ph_ci[3] !== 1'b1 || ph_fn[2] !== 3'd3 || ph_fn[3] !== 3'd3 ||
            ph_op[1] !== 8'h3E || ph_op[2] !== 8'h3F) begin
            bad++;
            $display("FAIL sbc_alu_drive: got ci=%b/%b fn=%0d/%0d op=%h/%h, need ci=1/1 fn=3/3 op=3e/3f",
                     ph_ci[2], ph_ci[3], ph_fn[2], ph_fn[3], ph_op[1], ph_op[2]);
        end
        do_op(3'd2, 8'h10, 8'h01, 1'b1, lat, d, f, w);
        total++;
        if (d !== 8'h0F || f !== 4'b0110 || ph_ci[2] !== 1'b0) begin
            bad++;
            $display("FAIL sub_10_01: got d=%h f=%b ci=%b, need d=0f f=0110 ci=0", d, f, ph_ci[2]);
        end
    endtask

    task automatic test_logic;
        int lat;
        logic [7:0] d;
        logic [3:0] f;
        logic w;
        do_op(3'd5, 8'h5A, 8'h5A, 1'b1, lat, d, f, w);
        total++;
        if (d !== 8'h00 || f !== 4'b1000 || w !== 1'b1) begin
            bad++;
            $display("FAIL xor_5a_5a: got d=%h f=%b wr=%b, need d=00 f=1000 wr=1", d, f, w);
        end
        do_op(3'd4, 8'hF0, 8'h0F, 1'b0, lat, d, f, w);
        total++;
        if (d !== 8'h00 || f !== 4'b1010) begin
            bad++;
            $display("FAIL and_f0_0f: got d=%h f=%b, need d=00 f=1010", d, f);
        end
        do_op(3'd6, 8'h12, 8'h40, 1'b0, lat, d, f, w);
        total++;
        if (d !== 8'h52 || f !== 4'b0000 || ph_fn[2] !== 3'd6) begin
            bad++;
            $display("FAIL or_12_40: got d=%h f=%b fn=%0d, need d=52 f=0000 fn=6", d, f, ph_fn[2]);
        end
    endtask

    task automatic test_cp_strobes;
        int lat;
        logic [7:0] d;
        logic [3:0] f;
        logic w;
        do_op(3'd7, 8'h10, 8'h10, 1'b1, lat, d, f, w);
        total++;
        if (d !== 8'h00 || f !== 4'b1100 || w !== 1'b0 || lat !== 4) begin
            bad++;
            $display("FAIL cp_10_10: got d=%h f=%b wr=%b lat=%0d, need d=00 f=1100 wr=0 lat=4",
                     d, f, w, lat);
        end
        total++;
        if (ph_strb[1] !== 5'b10000 || ph_strb[2] !== 5'b01100 || ph_strb[3] !== 5'b00011 ||
            ph_strb[4] !== 5'b00000) begin
            bad++;
            $display("FAIL phase_strobes: got %b %b %b %b, need 10000 01100 00011 00000",
                     ph_strb[1], ph_strb[2], ph_strb[3], ph_strb[4]);
        end
        total++;
        if (ph_fn[2] !== 3'd2 || ph_fn[3] !== 3'd2 || ph_ci[2] !== 1'b0 || ph_fn[1] !== 3'd0 ||
            ph_fn[4] !== 3'd0) begin
            bad++;
            $display("FAIL cp_fn_drive: got fn=%0d/%0d/%0d/%0d ci=%b, need fn=0/2/2/0 ci=0",
                     ph_fn[1], ph_fn[2], ph_fn[3], ph_fn[4], ph_ci[2]);
        end
    endtask

    task automatic test_backpressure;
        int k;
        int unstable;
        @(negedge clk);
        req_fn = 3'd0;
        req_a = 8'h22;
        req_b = 8'h11;
        req_cin = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 10);
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL bp_rsp_timeout: got rsp_valid=%b after %0d cycles, need 1", rsp_valid, k);
        end
        unstable = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h33 || rsp_flags !== 4'b0000 ||
                rsp_wr !== 1'b1 || req_ready !== 1'b0) unstable++;
            @(negedge clk);
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d unstable cycles (last vld=%b d=%h rdy=%b), need 0",
                     unstable, rsp_valid, rsp_data, req_ready);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got vld=%b rdy=%b, need vld=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        int c1, c2, nacc, nrsp;
        logic [7:0] d1, d2;
        int exp_gap;
`ifdef ALU_SEQ_B2B_EN
        exp_gap = 4;
`else
        exp_gap = 5;
`endif
        c1 = -1;
        c2 = -1;
        nacc = 0;
        nrsp = 0;
        d1 = 8'hXX;
        d2 = 8'hXX;
        @(negedge clk);
        req_fn = 3'd0;
        req_a = 8'h01;
        req_b = 8'h02;
        req_cin = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (rsp_valid) begin
                if (nrsp == 0) d1 = rsp_data;
                else d2 = rsp_data;
                nrsp++;
            end
            if (req_valid && req_ready) begin
                if (nacc == 0) c1 = cyc;
                else c2 = cyc;
                nacc++;
            end
            @(negedge clk);
            if (nacc == 1) begin
                req_fn = 3'd5;
                req_a = 8'hFF;
                req_b = 8'h0F;
            end else if (nacc >= 2) begin
                req_valid = 1'b0;
            end
            if (nrsp >= 2) break;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        total++;
        if (c1 < 0 || c2 < 0 || (c2 - c1) != exp_gap) begin
            bad++;
            $display("FAIL b2b_spacing: got accepts at %0d and %0d, need spacing %0d", c1, c2, exp_gap);
        end
        total++;
        if (d1 !== 8'h03 || d2 !== 8'hF0) begin
            bad++;
            $display("FAIL b2b_data: got %h %h, need 03 f0", d1, d2);
        end
    endtask

    task automatic test_async_reset;
        int seen;
        int lat;
        logic [7:0] d;
        logic [3:0] f;
        logic w;
        @(negedge clk);
        req_fn = 3'd3;
        req_a = 8'h3E;
        req_b = 8'h3F;
        req_cin = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (alu_l !== 1'b1 || alu_ci !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_lo: got alu_l=%b ci=%b, need 1 1", alu_l, alu_ci);
        end
        #2 nreset = 1'b0;
        #1;
        total++;
        if (alu_op !== 8'd0 || {alu_la, alu_lb, alu_l, alu_h, alu_oe, alu_ci} !== 6'd0 ||
            alu_fn !== 3'd0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got op=%h strb=%b fn=%0d rdy=%b vld=%b, need 0 0 0 1 0",
                     alu_op, {alu_la, alu_lb, alu_l, alu_h, alu_oe, alu_ci}, alu_fn, req_ready,
                     rsp_valid);
        end
        @(negedge clk);
        nreset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL dropped_op: got rsp_valid in %0d cycles after reset, need 0", seen);
        end
        do_op(3'd0, 8'h3A, 8'hC6, 1'b0, lat, d, f, w);
        total++;
        if (lat !== 4 || d !== 8'h00 || f !== 4'b1011) begin
            bad++;
            $display("FAIL post_reset_add: got lat=%0d d=%h f=%b, need lat=4 d=00 f=1011", lat, d, f);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_cp_strobes();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Micro-sequencer directly upstream of the nibble-serial ALU. Accepts one 8-bit ALU operation per request (opcode, operand A, operand B, carry-in), drives the ALU control lines through its three-phase sequence (load A, load B + low nibble, high nibble + result out), and captures the result and flags. It returns them to the decode/register-file stage over a valid/ready response port. Flag semantics follow LR35902 (Z, N, H, C).

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, all state on rising edge
- nreset  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept request
- req_fn  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- req_a  in  8  operand A
- req_b  in  8  operand B
- req_cin  in  1  current C flag, used by ADC/SBC only
- alu_op  out  8  operand bus into ALU
- alu_la  out  1  load ALU A latch from operand bus
- alu_lb  out  1  load ALU B latch from operand bus
- alu_fn  out  3  function select, equals latched req_fn (CP drives 2, SUB)
- alu_ci  out  1  carry-in to low nibble
- alu_l  out  1  low-nibble phase
- alu_h  out  1  high-nibble phase
- alu_oe  out  1  ALU result onto output (1) vs operand pass-through (0)
- alu_result  in  8  ALU result, valid combinationally in H phase
- alu_zero  in  1  result == 0, valid in H phase
- alu_carry  in  1  nibble carry/borrow out of current phase
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_data  out  8  result byte
- rsp_wr  out  1  1 = write rsp_data to destination (0 for CP)
- rsp_flags  out  4  {Z, N, H, C}

## Operation
- FSM states: IDLE, LDA, LO, HI, DONE.
- IDLE: req_ready=1. On req_valid, latch fn/a/b/cin, go to LDA.
- LDA: alu_op=a, alu_la=1. Go to LO.
- LO: alu_op=b, alu_lb=1, alu_l=1, alu_fn, alu_ci driven. At clock edge, register H_raw = alu_carry. Go to HI.
- HI: alu_h=1, alu_oe=1, alu_fn and alu_ci held. At clock edge, register result, zero, C_raw = alu_carry. Go to DONE.
- DONE: rsp_valid=1, outputs stable. On rsp_ready, go to IDLE (see Configuration).
- alu_ci: ADD/SUB/CP/logic = 0; ADC/SBC = latched cin.
- Flags: Z = alu_zero all ops. N = 1 for SUB/SBC/CP, else 0. H = H_raw for arithmetic, 1 for AND, 0 for XOR/OR. C = C_raw for arithmetic, 0 for logic. For SUB/SBC/CP, alu_carry is borrow.
- rsp_wr = 0 for CP, 1 otherwise. rsp_data for CP still equals a−b.
- Outside active phases: alu_op=0, all ALU strobes 0, alu_fn/alu_ci = 0.
- Reset (any time, incl. mid-sequence): state IDLE, all outputs 0 except req_ready=1. In-flight op is dropped, no response.
- Request inputs are ignored outside IDLE. req_valid must hold until accepted.

## Timing
- Accept at edge E. LDA in cycle E+1, LO in E+2, HI in E+3. rsp_valid asserted from E+4.
- Latency request-accept → rsp_valid: 4 cycles.
- Back-pressure: DONE held indefinitely while rsp_ready=0. rsp_* are constant during the hold.
- Throughput without macro: 5 cycles/op minimum.

## Configuration
- ALU_SEQ_B2B_EN defined: in DONE, req_ready = rsp_ready. Same-cycle rsp handshake + req_valid latches the new request and goes straight to LDA. Throughput 4 cycles/op.
- Undefined: req_ready=0 in DONE. Always returns to IDLE. Throughput 5 cycles/op.

## Test plan
- ADD a=0x3A b=0xC6 -> rsp_data=0x00, flags Z1 N0 H1 C1, rsp_wr=1, rsp_valid 4 cycles after accept.
- SBC a=0x3E b=0x3F cin=1 -> alu_ci=1 in LO/HI. With ALU model: 0xFE, Z0 N1 H1 C1.
- XOR a=0x5A b=0x5A -> 0x00, Z1 N0 H0 C0. AND 0xF0&0x0F -> 0x00, Z1 H1 C0.
- CP a=0x10 b=0x10 -> Z1 N1 H0 C0, rsp_wr=0. Check alu_la only in LDA, alu_lb/alu_l only in LO, alu_h/alu_oe only in HI.
- Back-pressure: hold rsp_ready=0 for 6 cycles -> rsp stable, req_ready=0. Then two queued requests -> second accepted at 4-cycle spacing with ALU_SEQ_B2B_EN, 5 without.
- Deassert nreset during LO -> outputs 0 immediately (async), req_ready=1, no rsp_valid. Next request completes normally.
